// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for the multicycle MIPS datapath.
//
// Steps each instruction through FETCH / DECODE / execute / memory /
// writeback states and drives the datapath write strobes, operand selects
// and the ALU operation code consumed by the shared alu block.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   op, funct         IR[31:26], IR[5:0] from the external instruction register
//   zero              ALU zero flag (branch resolution)
//   pc_write, ir_write, mem_read, mem_write, reg_write   datapath strobes
//   iord              memory address select (0 PC, 1 ALUOut)
//   alu_src_a         ALU A select (0 PC, 1 rs)
//   alu_src_b         ALU B select (rt, 4, ext imm, sext imm << 2)
//   ext_zero          1 = zero-extend immediate
//   alu_op            ALU operation code (ALUOp_* values)
//   reg_dst           destination select (rt, rd, $31)
//   wd_sel            register write data select (ALUOut, MDR, PC)
//   pc_src            next-PC select (ALU result, ALUOut, jump target)
//   illegal           one-cycle pulse on an unsupported opcode / funct
//   state             current state, for debug
//
// Build option: define MC_CTRL_JAL_EN to support jal (op 000011); without it
// jal decodes as illegal.
//
// ALU op codes normally come from ctrl_encode_def.v; the fallback values
// below are only used when that header has not been included first.

`ifndef ALUOp_NOP
  `define ALUOp_NOP  5'd0
`endif
`ifndef ALUOp_ADDU
  `define ALUOp_ADDU 5'd1
`endif
`ifndef ALUOp_SUBU
  `define ALUOp_SUBU 5'd2
`endif
`ifndef ALUOp_ADD
  `define ALUOp_ADD  5'd3
`endif
`ifndef ALUOp_SUB
  `define ALUOp_SUB  5'd4
`endif
`ifndef ALUOp_AND
  `define ALUOp_AND  5'd5
`endif
`ifndef ALUOp_OR
  `define ALUOp_OR   5'd6
`endif
`ifndef ALUOp_SLT
  `define ALUOp_SLT  5'd7
`endif
`ifndef ALUOp_SLL
  `define ALUOp_SLL  5'd8
`endif
`ifndef ALUOp_SRL
  `define ALUOp_SRL  5'd9
`endif
`ifndef ALUOp_SRA
  `define ALUOp_SRA  5'd10
`endif
`ifndef ALUOp_LUI
  `define ALUOp_LUI  5'd11
`endif
`ifndef ALUOp_LW
  `define ALUOp_LW   5'd12
`endif
`ifndef ALUOp_SW
  `define ALUOp_SW   5'd13
`endif
`ifndef ALUOp_EQL
  `define ALUOp_EQL  5'd14
`endif
`ifndef ALUOp_BNE
  `define ALUOp_BNE  5'd15
`endif

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [4:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // R-type funct -> ALU op. Every supported funct maps to a non-NOP code,
  // so NOP doubles as the "unsupported funct" marker in DECODE.
  function automatic logic [4:0] r_alu_op(input logic [5:0] f);
    case (f)
      6'b100001: r_alu_op = `ALUOp_ADDU;
      6'b100011: r_alu_op = `ALUOp_SUBU;
      6'b100000: r_alu_op = `ALUOp_ADD;
      6'b100010: r_alu_op = `ALUOp_SUB;
      6'b100100: r_alu_op = `ALUOp_AND;
      6'b100101: r_alu_op = `ALUOp_OR;
      6'b101010: r_alu_op = `ALUOp_SLT;
      6'b000000: r_alu_op = `ALUOp_SLL;
      6'b000010: r_alu_op = `ALUOp_SRL;
      6'b000011: r_alu_op = `ALUOp_SRA;
      default:   r_alu_op = `ALUOp_NOP;
    endcase
  endfunction

  state_t cur, nxt;
  logic   pcw_c, irw_c, mr_c, mw_c, rw_c, ill_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt       = FETCH;
    pcw_c     = 1'b0;
    irw_c     = 1'b0;
    mr_c      = 1'b0;
    mw_c      = 1'b0;
    rw_c      = 1'b0;
    ill_c     = 1'b0;
    iord      = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_zero  = 1'b0;
    alu_op    = `ALUOp_NOP;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    pc_src    = 2'b00;
    case (cur)
      FETCH: begin
        mr_c      = 1'b1;
        irw_c     = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = `ALUOp_ADDU;
        pcw_c     = 1'b1;
        nxt       = DECODE;
      end
      DECODE: begin
        // branch target PC + (sext(imm) << 2) lands in ALUOut here
        alu_src_b = 2'b11;
        alu_op    = `ALUOp_ADDU;
        case (op)
          OP_R: begin
            if (r_alu_op(funct) != `ALUOp_NOP) nxt = EXEC_R;
            else                                ill_c = 1'b1;
          end
          OP_LW, OP_SW:                       nxt = MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:   nxt = EXEC_I;
          OP_BEQ, OP_BNE:                     nxt = BRANCH;
          OP_J:                               nxt = JUMP;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:                             nxt = JUMP;
`endif
          default:                            ill_c = 1'b1;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op(funct);
        nxt       = R_WB;
      end
      R_WB: begin
        rw_c    = 1'b1;
        reg_dst = 2'b01;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_SW) begin
          alu_op = `ALUOp_SW;
          nxt    = MEM_WRITE;
        end else begin
          alu_op = `ALUOp_LW;
          nxt    = MEM_READ;
        end
      end
      MEM_READ: begin
        mr_c = 1'b1;
        iord = 1'b1;
        nxt  = MEM_WB;
      end
      MEM_WB: begin
        rw_c   = 1'b1;
        wd_sel = 2'b01;
      end
      MEM_WRITE: begin
        mw_c = 1'b1;
        iord = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_zero  = (op == OP_ORI);
        case (op)
          OP_ADDI: alu_op = `ALUOp_ADD;
          OP_SLTI: alu_op = `ALUOp_SLT;
          OP_ORI:  alu_op = `ALUOp_OR;
          OP_LUI:  alu_op = `ALUOp_LUI;
          default: alu_op = `ALUOp_NOP;
        endcase
        nxt = I_WB;
      end
      I_WB: begin
        // immediate extension must match EXEC_I while ALUOut is written back
        rw_c     = 1'b1;
        ext_zero = (op == OP_ORI);
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = (op == OP_BNE) ? `ALUOp_BNE : `ALUOp_EQL;
        pc_src    = 2'b01;
        pcw_c     = zero;
      end
      JUMP: begin
        pc_src = 2'b10;
        pcw_c  = 1'b1;
`ifdef MC_CTRL_JAL_EN
        // PC was already incremented in FETCH, so it is the link address
        if (op == OP_JAL) begin
          rw_c    = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
        end
`endif
      end
      default: nxt = FETCH;
    endcase
  end

  // Reset holds state at FETCH, so selects already show FETCH values;
  // only the strobes need masking while rst is high.
  assign pc_write  = pcw_c & ~rst;
  assign ir_write  = irw_c & ~rst;
  assign mem_read  = mr_c  & ~rst;
  assign mem_write = mw_c  & ~rst;
  assign reg_write = rw_c  & ~rst;
  assign illegal   = ill_c & ~rst;
  assign state     = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`ifndef ALUOp_NOP
  `define ALUOp_NOP  5'd0
`endif
`ifndef ALUOp_ADDU
  `define ALUOp_ADDU 5'd1
`endif
`ifndef ALUOp_SUBU
  `define ALUOp_SUBU 5'd2
`endif
`ifndef ALUOp_ADD
  `define ALUOp_ADD  5'd3
`endif
`ifndef ALUOp_SUB
  `define ALUOp_SUB  5'd4
`endif
`ifndef ALUOp_AND
  `define ALUOp_AND  5'd5
`endif
`ifndef ALUOp_OR
  `define ALUOp_OR   5'd6
`endif
`ifndef ALUOp_SLT
  `define ALUOp_SLT  5'd7
`endif
`ifndef ALUOp_SLL
  `define ALUOp_SLL  5'd8
`endif
`ifndef ALUOp_SRL
  `define ALUOp_SRL  5'd9
`endif
`ifndef ALUOp_SRA
  `define ALUOp_SRA  5'd10
`endif
`ifndef ALUOp_LUI
  `define ALUOp_LUI  5'd11
`endif
`ifndef ALUOp_LW
  `define ALUOp_LW   5'd12
`endif
`ifndef ALUOp_SW
  `define ALUOp_SW   5'd13
`endif
`ifndef ALUOp_EQL
  `define ALUOp_EQL  5'd14
`endif
`ifndef ALUOp_BNE
  `define ALUOp_BNE  5'd15
`endif

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, iord;
  logic       alu_src_a, ext_zero, illegal;
  logic [1:0] alu_src_b, reg_dst, wd_sel, pc_src;
  logic [4:0] alu_op;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_op(alu_op), .reg_dst(reg_dst), .wd_sel(wd_sel), .pc_src(pc_src),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // One expected output vector per clock cycle.
  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mr, mw, rw, iord, sa;
    logic [1:0] sb;
    logic       ez;
    logic [4:0] aop;
    logic [1:0] rd, wd, ps;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   mw_cnt = 0;
  int   ill_cnt = 0;

  function automatic exp_t blank(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  // Instruction -> ALU op for the execute step; NOP means unsupported.
  function automatic logic [4:0] r_op_of(input logic [5:0] f);
    logic [4:0] r;
    r = `ALUOp_NOP;
    if (f == 6'h21) r = `ALUOp_ADDU;
    if (f == 6'h23) r = `ALUOp_SUBU;
    if (f == 6'h20) r = `ALUOp_ADD;
    if (f == 6'h22) r = `ALUOp_SUB;
    if (f == 6'h24) r = `ALUOp_AND;
    if (f == 6'h25) r = `ALUOp_OR;
    if (f == 6'h2a) r = `ALUOp_SLT;
    if (f == 6'h00) r = `ALUOp_SLL;
    if (f == 6'h02) r = `ALUOp_SRL;
    if (f == 6'h03) r = `ALUOp_SRA;
    return r;
  endfunction

  // Model: expands one instruction into its full per-cycle output sequence.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    exp_t e;
    logic jal_ok;
`ifdef MC_CTRL_JAL_EN
    jal_ok = 1'b1;
`else
    jal_ok = 1'b0;
`endif
    e = blank(4'd0); e.mr = 1; e.irw = 1; e.sb = 2'b01; e.aop = `ALUOp_ADDU; e.pcw = 1;
    q.push_back(e);
    e = blank(4'd1); e.sb = 2'b11; e.aop = `ALUOp_ADDU;
    if (o == 6'h00 && r_op_of(f) != `ALUOp_NOP) begin
      q.push_back(e);
      e = blank(4'd6); e.sa = 1; e.aop = r_op_of(f); q.push_back(e);
      e = blank(4'd7); e.rw = 1; e.rd = 2'b01; q.push_back(e);
    end else if (o == 6'h23 || o == 6'h2b) begin
      q.push_back(e);
      e = blank(4'd2); e.sa = 1; e.sb = 2'b10;
      e.aop = (o == 6'h23) ? `ALUOp_LW : `ALUOp_SW; q.push_back(e);
      if (o == 6'h23) begin
        e = blank(4'd3); e.mr = 1; e.iord = 1; q.push_back(e);
        e = blank(4'd4); e.rw = 1; e.wd = 2'b01; q.push_back(e);
      end else begin
        e = blank(4'd5); e.mw = 1; e.iord = 1; q.push_back(e);
      end
    end else if (o == 6'h08 || o == 6'h0a || o == 6'h0d || o == 6'h0f) begin
      q.push_back(e);
      e = blank(4'd8); e.sa = 1; e.sb = 2'b10; e.ez = (o == 6'h0d);
      e.aop = (o == 6'h08) ? `ALUOp_ADD : (o == 6'h0a) ? `ALUOp_SLT :
              (o == 6'h0d) ? `ALUOp_OR : `ALUOp_LUI;
      q.push_back(e);
      e = blank(4'd9); e.rw = 1; e.ez = (o == 6'h0d); q.push_back(e);
    end else if (o == 6'h04 || o == 6'h05) begin
      q.push_back(e);
      e = blank(4'd10); e.sa = 1; e.ps = 2'b01; e.pcw = z;
      e.aop = (o == 6'h04) ? `ALUOp_EQL : `ALUOp_BNE; q.push_back(e);
    end else if (o == 6'h02 || (o == 6'h03 && jal_ok)) begin
      q.push_back(e);
      e = blank(4'd11); e.ps = 2'b10; e.pcw = 1;
      if (o == 6'h03) begin e.rw = 1; e.rd = 2'b10; e.wd = 2'b10; end
      q.push_back(e);
    end else begin
      e.ill = 1; q.push_back(e);
    end
  endtask

  // Per-cycle compare against the model while an instruction is in flight.
  always @(negedge clk) begin
    exp_t a, e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      a = {state, pc_write, ir_write, mem_read, mem_write, reg_write, iord,
           alu_src_a, alu_src_b, ext_zero, alu_op, reg_dst, wd_sel, pc_src, illegal};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle st=%0d op=%b funct=%b: got %h want %h", e.st, op, funct, a, e);
      end
      if (mem_write) mw_cnt++;
      if (illegal) ill_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge while the DUT sits in FETCH.
  task automatic issue(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int exp_cpi);
    int n;
    op = o; funct = f; zero = z;
    mw_cnt = 0; ill_cnt = 0;
    push_instr(o, f, z);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (state != 4'd0 && n < 20);
    chk({name, " cpi"}, n, exp_cpi);
    q.delete();
  endtask

  initial begin
    int n;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst state", state, 0);
    chk("rst strobes", {pc_write, ir_write, mem_read, mem_write, reg_write, illegal}, 0);
    chk("rst alu_src_b", alu_src_b, 1);
    chk("rst alu_op", alu_op, `ALUOp_ADDU);
    rst = 1'b0;

    issue("addu", 6'h00, 6'h21, 1'b0, 4);
    issue("lw",   6'h23, 6'h00, 1'b0, 5);
    issue("sw",   6'h2b, 6'h00, 1'b0, 4);
    chk("sw mem_write count", mw_cnt, 1);
    issue("beq z1", 6'h04, 6'h00, 1'b1, 3);
    issue("beq z0", 6'h04, 6'h00, 1'b0, 3);
    issue("bne z1", 6'h05, 6'h00, 1'b1, 3);
    issue("bne z0", 6'h05, 6'h00, 1'b0, 3);
    issue("ori",  6'h0d, 6'h00, 1'b0, 4);
    issue("addi", 6'h08, 6'h3f, 1'b0, 4);
    issue("slti", 6'h0a, 6'h00, 1'b0, 4);
    issue("lui",  6'h0f, 6'h00, 1'b0, 4);
    issue("subu", 6'h00, 6'h23, 1'b0, 4);
    issue("add",  6'h00, 6'h20, 1'b0, 4);
    issue("sub",  6'h00, 6'h22, 1'b0, 4);
    issue("and",  6'h00, 6'h24, 1'b0, 4);
    issue("or",   6'h00, 6'h25, 1'b0, 4);
    issue("slt",  6'h00, 6'h2a, 1'b0, 4);
    issue("sll",  6'h00, 6'h00, 1'b0, 4);
    issue("srl",  6'h00, 6'h02, 1'b0, 4);
    issue("sra",  6'h00, 6'h03, 1'b0, 4);
    issue("j",    6'h02, 6'h00, 1'b0, 3);
    issue("op3f", 6'h3f, 6'h00, 1'b0, 2);
    chk("op3f illegal pulses", ill_cnt, 1);
    issue("bad funct", 6'h00, 6'h3f, 1'b0, 2);
    chk("bad funct illegal pulses", ill_cnt, 1);
`ifdef MC_CTRL_JAL_EN
    issue("jal", 6'h03, 6'h00, 1'b0, 3);
    chk("jal illegal pulses", ill_cnt, 0);
`else
    issue("jal", 6'h03, 6'h00, 1'b0, 2);
    chk("jal illegal pulses", ill_cnt, 1);
`endif

    // reset in the middle of a store
    op = 6'h2b; funct = 6'h00; zero = 1'b0;
    push_instr(6'h2b, 6'h00, 1'b0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (state != 4'd5 && n < 20);
    chk("reach MEM_WRITE", state, 5);
    chk("mem_write before rst", mem_write, 1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort mem_write", mem_write, 0);
    chk("abort state", state, 0);
    chk("abort pc_write", pc_write, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post-rst pc_write", pc_write, 1);
    chk("post-rst alu_op", alu_op, `ALUOp_ADDU);
    issue("addu after rst", 6'h00, 6'h21, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the ALU's `ALUOp` code, operand selects and all datapath write strobes. It sits beside the shared `alu` block: it is the producer of `alu_op`, and it consumes the ALU's `zero` flag for branches. `op` and `funct` come from the external instruction register, which this block loads via `ir_write`.

## Interface
- No parameters. ALU op values are the `ALUOp_*` macros from `ctrl_encode_def.v`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC load strobe.
- `ir_write` out 1: IR load strobe.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `reg_write` out 1: register file write strobe.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = rs register.
- `alu_src_b` out 2: ALU B select. 00 = rt register, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- `ext_zero` out 1: 1 = zero-extend the immediate, 0 = sign-extend.
- `alu_op` out 5: ALU operation code.
- `reg_dst` out 2: destination register select. 00 = rt, 01 = rd, 10 = $31.
- `wd_sel` out 2: register write data select. 00 = ALUOut, 01 = MDR, 10 = PC.
- `pc_src` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `state` out 4: current state, for debug.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5.
  - EXEC_R = 6, R_WB = 7, EXEC_I = 8, I_WB = 9, BRANCH = 10, JUMP = 11.
  - Codes 12–15 are unused. Any of them goes to FETCH on the next clock.
- Unless listed otherwise, every strobe is 0 and every select is 0.
- FETCH: `mem_read`=1, `ir_write`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADDU, `pc_src`=00, `pc_write`=1. Next state is DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADDU, which computes the branch target into ALUOut. Next state by opcode:
  - R-type (000000) with a legal funct → EXEC_R.
  - lw (100011) or sw (101011) → MEM_ADDR.
  - addi (001000), slti (001010), ori (001101), lui (001111) → EXEC_I.
  - beq (000100), bne (000101) → BRANCH.
  - j (000010) → JUMP.
  - Anything else: `illegal`=1 in this cycle, next state FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00. `alu_op` by funct:
  - 100001 → ADDU; 100011 → SUBU; 100000 → ADD; 100010 → SUB.
  - 100100 → AND; 100101 → OR; 101010 → SLT.
  - 000000 → SLL; 000010 → SRL; 000011 → SRA.
  - Next state R_WB.
- R_WB: `reg_write`=1, `reg_dst`=01, `wd_sel`=00. Next state FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op` = LW or SW according to `op`. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `iord`=1. Next state MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=00, `wd_sel`=01. Next state FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1. Next state FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10. Next state I_WB. `alu_op` by opcode:
  - addi → ADD; slti → SLT; lui → LUI.
  - ori → OR, with `ext_zero`=1.
- I_WB: `reg_write`=1, `reg_dst`=00, `wd_sel`=00. `ext_zero` holds its EXEC_I value. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op` = EQL for beq or BNE for bne, `pc_src`=01. Next state FETCH.
  - `pc_write` = `zero`. This is the only Mealy output.
- JUMP: `pc_src`=10, `pc_write`=1. Next state FETCH.

## Timing
- Outputs are combinational decodes of the registered `state`, plus `zero` in BRANCH and `op`/`funct` in DECODE, EXEC_*, MEM_ADDR and BRANCH.
- Cycles per instruction:
  - lw: 5.
  - R-type, I-type, sw: 4.
  - beq, bne, j, illegal: 3, 3, 3, 2.
- `rst` asserted: `state` = FETCH (0) immediately.
  - While `rst` is high, `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write` and `illegal` are forced to 0.
  - All selects and `alu_op` show FETCH values: `alu_src_b`=01, `alu_op`=ADDU, the rest 0.
- Reset asserted mid-instruction aborts it, with no further strobes. The first fetch happens on the first rising edge after `rst` falls.
- `op` and `funct` must stay stable from the end of FETCH until the return to FETCH. IR changes only on FETCH edges.

## Configuration
- `MC_CTRL_JAL_EN` defined: op 000011 (jal) goes DECODE → JUMP.
  - JUMP then also asserts `reg_write`=1, `reg_dst`=10, `wd_sel`=10, writing the already-incremented PC to $31 in the same cycle.
- Without the macro: op 000011 is illegal, and JUMP never asserts `reg_write`.

## Test plan
- Reset: assert `rst` mid-MEM_WRITE → `mem_write` drops to 0 immediately and `state` = 0. Release → FETCH with `pc_write`=1 and `alu_op`=ADDU.
- addu (op 000000, funct 100001) → states 0, 1, 6, 7, 0; `alu_op`=ADDU in EXEC_R; `reg_write`=1 with `reg_dst`=01 only in R_WB.
- lw then sw → lw takes 5 cycles with `alu_op`=LW and `mem_read`+`iord` in MEM_READ. sw takes 4 cycles with `mem_write`=1 exactly once.
- beq with `zero`=1, then with `zero`=0 → `pc_write`=1 and `pc_src`=01 in BRANCH for the first; `pc_write`=0 for the second.
- ori (001101) → `ext_zero`=1 in EXEC_I and I_WB, `alu_op`=OR. Opcode 111111 → `illegal` high for one cycle in DECODE, next state FETCH.
- jal (000011), built with and without `MC_CTRL_JAL_EN` → with the macro: JUMP has `reg_write`=1, `reg_dst`=10, `wd_sel`=10. Without it: `illegal` pulses.
